entrada_senha: RTL
==================

ENTRADA_SENHA -- requirements
Module: entrada_senha

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000, consecutive stable cycles required to accept a button level change (must be >= 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 250000000, idle cycles during password entry before inactivity timeout (must be >= 2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port B  input  4  raw push-buttons, active-low, asynchronous to clk, bouncing.
REQ-006 SHALL have port S_INATI  input  1  high while the password FSM is in an entry state; arms the inactivity timer.
REQ-007 SHALL have port COD  output  2  code of the last accepted button.
REQ-008 SHALL have port EN  output  1  one-cycle pulse marking a newly accepted button; COD is valid in the same cycle.
REQ-009 SHALL have port TEMP_INATI  output  1  level, inactivity timeout reached.

Function
REQ-010 SHALL pass each B bit through a 2-flip-flop synchronizer before any other use.
REQ-011 SHALL keep a per-button debounced level and counter: counter clears when synchronized level equals debounced level, increments otherwise; on the edge where it would reach DEB_CYCLES, debounced level takes the synchronized level and counter clears.
REQ-012 SHALL size counters as $clog2(DEB_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1) bits; counters never wrap.
REQ-013 SHALL implement a press FSM with states IDLE and HELD.
REQ-014 IDLE -> HELD when exactly one debounced button is pressed (low); EN=1 for that one cycle, COD=index (B[0]->00, B[1]->01, B[2]->10, B[3]->11).
REQ-015 IDLE with two or more debounced buttons pressed simultaneously SHALL go to HELD without EN pulse and without COD change.
REQ-016 HELD -> IDLE only when all four debounced buttons are released; no EN while in HELD (extra presses ignored).
REQ-017 EN and COD SHALL be registered; press-to-EN latency: B[i] low and stable before edge k -> EN high for the single cycle following edge k+DEB_CYCLES+2.
REQ-018 COD SHALL hold its value between EN pulses.
REQ-019 Inactivity counter SHALL clear when S_INATI=0 or EN=1, else increment while TEMP_INATI=0.
REQ-020 TEMP_INATI SHALL be set on the edge where the counter increments from TIMEOUT_CYCLES-1 (i.e. TIMEOUT_CYCLES edges after S_INATI sampled high with no EN), held high until S_INATI sampled 0 or rst.
REQ-021 EN and TEMP_INATI in the same cycle SHALL not occur: when the counter would time out on an EN edge, EN wins and the counter clears.
REQ-022 EN SHALL be generated independently of S_INATI and TEMP_INATI.

Reset
REQ-023 rst=1 on an edge SHALL set synchronizers and debounced levels to 1 (released), all counters to 0, FSM to IDLE, EN=0, COD=00, TEMP_INATI=0.
REQ-024 rst asserted mid-press or mid-timeout SHALL discard progress; a button still held after rst needs a full DEB_CYCLES to be accepted and then produces EN.

Verification (DEB_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-025 Clean B[2] press at edge 10, held 20 cycles -> single EN pulse after edge 16, COD=10; no second EN until release and re-press.
REQ-026 B[1] toggling every 2 cycles for 12 cycles then stable low -> no EN during bounce; exactly one EN with COD=01, 6 edges after stabilisation.
REQ-027 B[0] and B[3] pressed same cycle -> no EN, COD unchanged; release both then press B[3] -> one EN, COD=11.
REQ-028 S_INATI=1 from edge 0, no presses -> TEMP_INATI rises after edge 16, stays high; S_INATI=0 -> TEMP_INATI=0 next edge.
REQ-029 S_INATI=1, B[0] EN at counter=15 -> no TEMP_INATI; counter restarts, timeout 16 edges after EN.
REQ-030 rst pulse for 1 cycle while B[2] debounce counter=3 and timer=10 -> all outputs 0, EN appears 6 edges after rst release if B[2] still low.

Source files
------------

// File: rtl/entrada_senha.sv
// ---------------------------------------------------------------------------
// entrada_senha
// Keypad front end for a password-entry controller. Four raw, bouncing,
// active-low push-buttons are synchronised, debounced and turned into a
// single "new key" pulse carrying the key code. An inactivity timer flags
// when the password FSM has waited too long for the next key.
//
// Parameters
//   DEB_CYCLES     : stable cycles needed to accept a button level change (>= 2)
//   TIMEOUT_CYCLES : idle cycles during entry before timeout (>= 2)
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   B          in   4  raw buttons, active-low, asynchronous, bouncing
//   S_INATI    in   1  high while the password FSM waits for a key
//   COD        out  2  code of the last accepted button
//   EN         out  1  one-cycle pulse: new button accepted, COD valid
//   TEMP_INATI out  1  level: inactivity timeout reached
// ---------------------------------------------------------------------------
module entrada_senha #(
    parameter int DEB_CYCLES     = 50000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] B,
    input  logic       S_INATI,
    output logic [1:0] COD,
    output logic       EN,
    output logic       TEMP_INATI
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Last count value before a level change is accepted / timeout fires.
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Synchroniser and debouncer state
    logic [3:0]    b_meta_r;
    logic [3:0]    b_sync_r;
    logic [3:0]    deb_level_r;
    logic [DW-1:0] deb_cnt_r [4];

    // Press FSM and registered outputs
    state_t        state_r;
    state_t        state_next_s;
    logic          en_r;
    logic          en_next_s;
    logic [1:0]    cod_r;
    logic [1:0]    cod_next_s;
    logic [3:0]    pressed_s;

    // Inactivity timer
    logic [TW-1:0] tmo_cnt_r;
    logic          tmo_r;

    // True when exactly one bit of the pressed vector is set.
    function automatic logic single_press(input logic [3:0] p);
        logic r;
        case (p)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Index of the pressed button; only meaningful for a one-hot vector.
    function automatic logic [1:0] press_index(input logic [3:0] p);
        logic [1:0] r;
        case (p)
            4'b0001: r = 2'd0;
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser; released (1) is the reset level.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_meta_r <= 4'b1111;
            b_sync_r <= 4'b1111;
        end else begin
            b_meta_r <= B;
            b_sync_r <= b_meta_r;
        end
    end

    // Per-button debouncer: a level change is accepted only after the
    // synchronised input has differed from the debounced level for
    // DEB_CYCLES consecutive edges. Any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level_r <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (b_sync_r[i] == deb_level_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_level_r[i] <= b_sync_r[i];
                    deb_cnt_r[i]   <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                end
            end
        end
    end

    assign pressed_s = ~deb_level_r;

    // Press FSM next-state logic. A key is reported only when it is the
    // sole pressed button leaving IDLE; chords and extra presses while
    // HELD are swallowed until every button is released.
    always_comb begin
        state_next_s = state_r;
        en_next_s    = 1'b0;
        cod_next_s   = cod_r;
        case (state_r)
            IDLE: begin
                if (pressed_s != 4'b0000) begin
                    state_next_s = HELD;
                    if (single_press(pressed_s)) begin
                        en_next_s  = 1'b1;
                        cod_next_s = press_index(pressed_s);
                    end else begin
                        en_next_s  = 1'b0;
                        cod_next_s = cod_r;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            HELD: begin
                if (pressed_s == 4'b0000) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HELD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Press FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            en_r    <= 1'b0;
            cod_r   <= 2'b00;
        end else begin
            state_r <= state_next_s;
            en_r    <= en_next_s;
            cod_r   <= cod_next_s;
        end
    end

    // Inactivity timer. It clears on the same edge that raises EN (using
    // the next-state value), so EN and a fresh timeout can never appear
    // together. The count stops once the flag is set, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= '0;
            tmo_r     <= 1'b0;
        end else if (!S_INATI) begin
            tmo_cnt_r <= '0;
            tmo_r     <= 1'b0;
        end else if (en_next_s) begin
            tmo_cnt_r <= '0;
        end else if (!tmo_r) begin
            if (tmo_cnt_r == TMO_LAST) begin
                tmo_r <= 1'b1;
            end
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
    end

    assign EN         = en_r;
    assign COD        = cod_r;
    assign TEMP_INATI = tmo_r;

endmodule
